// File: rtl/cache_fill_fsm.sv
// Cache block fill engine: on a miss, reads an 8-word block from a 4-cycle-latency
// memory with pipelined issue and streams it into the cache; forwards write-through stores when idle.
module cache_fill_fsm #(
  parameter int ADDR_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  miss_detected,
  input  logic [ADDR_WIDTH-1:0] miss_address,
  input  logic                  wr_req,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [15:0]           wr_data,
  output logic                  wr_ack,
  output logic                  fsm_busy,
  output logic                  write_data_array,
  output logic                  write_tag_array,
  output logic [ADDR_WIDTH-1:0] cache_word_addr,
  output logic [15:0]           cache_word_data,
  output logic                  mem_enable,
  output logic                  mem_wr,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [15:0]           mem_data_in,
  input  logic [15:0]           mem_data_out,
  input  logic                  mem_data_valid
);

  // Handshakes: wr_ack pulses in the single IDLE cycle a store reaches memory (wr_req is
  // not consumed otherwise); mem_data_valid qualifies mem_data_out for one cycle, in issue order.

  typedef enum logic {
    IDLE = 1'b0,
    FILL = 1'b1
  } state_t;

  localparam logic [ADDR_WIDTH-1:0] BLOCK_MASK = {{(ADDR_WIDTH-4){1'b1}}, 4'b0000};
  localparam logic [ADDR_WIDTH-1:0] WORD_MASK  = {{(ADDR_WIDTH-1){1'b1}}, 1'b0};

  state_t                state, state_nxt;
  logic [ADDR_WIDTH-1:0] base, base_nxt;
  logic [3:0]            issue_cnt, issue_nxt;
  logic [2:0]            recv_cnt, recv_nxt;
  logic [ADDR_WIDTH-1:0] issue_off, recv_off;

  assign issue_off = {{(ADDR_WIDTH-4){1'b0}}, issue_cnt[2:0], 1'b0};
  assign recv_off  = {{(ADDR_WIDTH-4){1'b0}}, recv_cnt, 1'b0};

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      base      <= '0;
      issue_cnt <= '0;
      recv_cnt  <= '0;
    end else begin
      state     <= state_nxt;
      base      <= base_nxt;
      issue_cnt <= issue_nxt;
      recv_cnt  <= recv_nxt;
    end
  end

  always_comb begin
    state_nxt        = state;
    base_nxt         = base;
    issue_nxt        = issue_cnt;
    recv_nxt         = recv_cnt;
    wr_ack           = 1'b0;
    fsm_busy         = 1'b0;
    write_data_array = 1'b0;
    write_tag_array  = 1'b0;
    cache_word_addr  = '0;
    cache_word_data  = '0;
    mem_enable       = 1'b0;
    mem_wr           = 1'b0;
    mem_addr         = '0;
    mem_data_in      = '0;
    // Outputs stay quiet for the whole reset cycle, even if reset lands mid-fill.
    if (!rst) begin
      case (state)
        IDLE: begin
          if (miss_detected) begin
            base_nxt  = miss_address & BLOCK_MASK;
            issue_nxt = '0;
            recv_nxt  = '0;
            fsm_busy  = 1'b1;
            state_nxt = FILL;
          end else if (wr_req) begin
            mem_enable  = 1'b1;
            mem_wr      = 1'b1;
            mem_addr    = wr_addr & WORD_MASK;
            mem_data_in = wr_data;
            wr_ack      = 1'b1;
          end
        end
        FILL: begin
          fsm_busy = 1'b1;
          if (!issue_cnt[3]) begin
            mem_enable = 1'b1;
            mem_addr   = base + issue_off;
            issue_nxt  = issue_cnt + 4'd1;
          end
          if (mem_data_valid) begin
            write_data_array = 1'b1;
            cache_word_addr  = base + recv_off;
            cache_word_data  = mem_data_out;
            recv_nxt         = recv_cnt + 3'd1;
            if (recv_cnt == 3'd7) begin
              write_tag_array = 1'b1;
              state_nxt       = IDLE;
            end
          end
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cache_fill_fsm.sv
// Bench for cache_fill_fsm: 4-cycle memory model, schedule-driven stimulus and a
// timeline reference model that predicts every output in every cycle.
module tb_cache_fill_fsm;

  localparam int AW   = 16;
  localparam int MAXC = 320;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        miss_detected = 1'b0;
  logic [15:0] miss_address = '0;
  logic        wr_req = 1'b0;
  logic [15:0] wr_addr = '0;
  logic [15:0] wr_data = '0;
  logic        wr_ack, fsm_busy, write_data_array, write_tag_array;
  logic [15:0] cache_word_addr, cache_word_data;
  logic        mem_enable, mem_wr;
  logic [15:0] mem_addr, mem_data_in;
  logic [15:0] mem_data_out = '0;
  logic        mem_data_valid = 1'b0;

  cache_fill_fsm #(.ADDR_WIDTH(AW)) dut (
    .clk              (clk),
    .rst              (rst),
    .miss_detected    (miss_detected),
    .miss_address     (miss_address),
    .wr_req           (wr_req),
    .wr_addr          (wr_addr),
    .wr_data          (wr_data),
    .wr_ack           (wr_ack),
    .fsm_busy         (fsm_busy),
    .write_data_array (write_data_array),
    .write_tag_array  (write_tag_array),
    .cache_word_addr  (cache_word_addr),
    .cache_word_data  (cache_word_data),
    .mem_enable       (mem_enable),
    .mem_wr           (mem_wr),
    .mem_addr         (mem_addr),
    .mem_data_in      (mem_data_in),
    .mem_data_out     (mem_data_out),
    .mem_data_valid   (mem_data_valid)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  typedef struct packed {
    logic        busy;
    logic        en;
    logic        wr;
    logic        wda;
    logic        tag;
    logic        ack;
    logic [15:0] addr;
    logic [15:0] din;
    logic [15:0] cwa;
    logic [15:0] cwd;
  } obs_t;

  int checks   = 0;
  int failures = 0;

  logic [15:0] ref_mem [0:32767];
  logic [15:0] mem     [0:32767];
  int          sync_gen  = 0;
  int          sync_seen = 0;
  logic        pend_v = 1'b0;
  logic [15:0] pend_d = '0;
  logic [3:0]  pipe_v = '0;
  logic [15:0] pipe_d [4];

  logic        s_rst  [MAXC];
  logic        s_miss [MAXC];
  logic        s_wr   [MAXC];
  logic [15:0] s_maddr[MAXC];
  logic [15:0] s_waddr[MAXC];
  logic [15:0] s_wdata[MAXC];
  obs_t        obs    [MAXC];
  obs_t        exp_c  [MAXC];
  logic [31:0] exp_q  [$];

  // ---------------- memory model: sees requests mid-cycle, returns reads 4 cycles later ----
  always @(negedge clk) begin
    pend_v = 1'b0;
    if (sync_gen != sync_seen) begin
      for (int i = 0; i < 32768; i++) mem[i] = ref_mem[i];
      sync_seen = sync_gen;
    end
    if (mem_enable === 1'b1) begin
      if (mem_wr === 1'b1) mem[mem_addr[15:1]] = mem_data_in;
      else begin
        pend_v = 1'b1;
        pend_d = mem[mem_addr[15:1]];
      end
    end
  end

  always @(posedge clk) begin
    #1;
    pipe_v    = {pipe_v[2:0], pend_v};
    pipe_d[3] = pipe_d[2];
    pipe_d[2] = pipe_d[1];
    pipe_d[1] = pipe_d[0];
    pipe_d[0] = pend_d;
    mem_data_valid = pipe_v[3];
    mem_data_out   = pipe_v[3] ? pipe_d[3] : 16'($urandom);
  end

  // ---------------- driver tasks ----------------
  task automatic sync_mem();
    sync_gen++;
    @(negedge clk);
    @(posedge clk); #1;
  endtask

  task automatic clear_sched();
    for (int t = 0; t < MAXC; t++) begin
      s_rst[t] = 1'b0; s_miss[t] = 1'b0; s_wr[t] = 1'b0;
      s_maddr[t] = '0; s_waddr[t] = '0; s_wdata[t] = '0;
    end
  endtask

  task automatic capture(input int n);
    for (int t = 0; t < n; t++) begin
      rst           = s_rst[t];
      miss_detected = s_miss[t];
      miss_address  = s_maddr[t];
      wr_req        = s_wr[t];
      wr_addr       = s_waddr[t];
      wr_data       = s_wdata[t];
      @(negedge clk);
      obs[t] = obs_t'({fsm_busy, mem_enable, mem_wr, write_data_array, write_tag_array, wr_ack,
                       mem_addr, mem_data_in, cache_word_addr, cache_word_data});
      @(posedge clk); #1;
    end
    rst = 1'b0; miss_detected = 1'b0; wr_req = 1'b0;
  endtask

  // ---------------- reference model: fill timeline relative to the miss cycle ----------------
  function automatic void build_expect(input int n);
    int          fs;
    int          rel;
    logic [15:0] fb;
    obs_t        e;
    fs = -1;
    fb = '0;
    exp_q.delete();
    for (int t = 0; t < n; t++) begin
      e = '0;
      if (s_rst[t]) fs = -1;
      else if (fs >= 0) begin
        rel    = t - fs;
        e.busy = 1'b1;
        if (rel >= 1 && rel <= 8) begin
          e.en   = 1'b1;
          e.addr = fb + 16'(2 * (rel - 1));
        end
        if (rel >= 5) begin
          e.wda = 1'b1;
          e.cwa = fb + 16'(2 * (rel - 5));
          e.cwd = ref_mem[e.cwa[15:1]];
          exp_q.push_back({e.cwa, e.cwd});
        end
        if (rel == 12) begin
          e.tag = 1'b1;
          fs    = -1;
        end
      end else if (s_miss[t]) begin
        e.busy = 1'b1;
        fs     = t;
        fb     = s_maddr[t] & 16'hFFF0;
      end else if (s_wr[t]) begin
        e.en   = 1'b1;
        e.wr   = 1'b1;
        e.ack  = 1'b1;
        e.addr = s_waddr[t] & 16'hFFFE;
        e.din  = s_wdata[t];
        ref_mem[e.addr[15:1]] = e.din;
      end
      exp_c[t] = e;
    end
  endfunction

  // ---------------- tests ----------------
  task automatic test_reset();
    clear_sched();
    for (int t = 0; t < 3; t++) begin
      s_rst[t] = 1'b1; s_miss[t] = 1'b1; s_maddr[t] = 16'($urandom);
      s_wr[t] = 1'b1; s_waddr[t] = 16'($urandom); s_wdata[t] = 16'($urandom);
    end
    s_wr[4] = 1'b1; s_waddr[4] = 16'h7F00 | 16'($urandom_range(0, 255)); s_wdata[4] = 16'($urandom);
    build_expect(6);
    capture(6);
    for (int t = 0; t < 6; t++) begin
      checks++;
      if (obs[t] !== exp_c[t]) begin
        failures++;
        $display("FAIL reset cycle %0d got=%h exp=%h", t, obs[t], exp_c[t]);
      end
    end
  endtask

  task automatic test_basic_fill();
    for (int k = 0; k < 8; k++) ref_mem[15'h0918 + 15'(k)] = 16'hA000 + 16'(k);
    sync_mem();
    clear_sched();
    s_miss[0] = 1'b1; s_maddr[0] = 16'h1234;
    build_expect(16);
    capture(16);
    for (int t = 0; t < 16; t++) begin
      checks++;
      if (obs[t] !== exp_c[t]) begin
        failures++;
        $display("FAIL basic_fill cycle %0d got=%h exp=%h", t, obs[t], exp_c[t]);
      end
    end
    checks++;
    if (obs[5].cwd !== 16'hA000 || obs[5].cwa !== 16'h1230) begin
      failures++;
      $display("FAIL basic_fill_word0 got=%h@%h exp=a000@1230", obs[5].cwd, obs[5].cwa);
    end
    checks++;
    if (obs[12].tag !== 1'b1 || obs[13].busy !== 1'b0) begin
      failures++;
      $display("FAIL basic_fill_end got=tag%b/busy%b exp=tag1/busy0", obs[12].tag, obs[13].busy);
    end
  endtask

  task automatic test_write_through();
    clear_sched();
    s_wr[0] = 1'b1; s_waddr[0] = 16'h0040; s_wdata[0] = 16'hBEEF;
    s_wr[2] = 1'b1; s_waddr[2] = 16'h2000 | 16'($urandom_range(0, 4095)); s_wdata[2] = 16'($urandom);
    s_miss[4] = 1'b1; s_maddr[4] = 16'h0046;
    build_expect(20);
    capture(20);
    for (int t = 0; t < 20; t++) begin
      checks++;
      if (obs[t] !== exp_c[t]) begin
        failures++;
        $display("FAIL write_through cycle %0d got=%h exp=%h", t, obs[t], exp_c[t]);
      end
    end
    checks++;
    if (obs[0].ack !== 1'b1 || obs[0].wr !== 1'b1 || obs[0].addr !== 16'h0040) begin
      failures++;
      $display("FAIL write_through_ack got=ack%b wr%b addr=%h exp=ack1 wr1 addr=0040",
               obs[0].ack, obs[0].wr, obs[0].addr);
    end
    checks++;
    if (obs[9].cwd !== 16'hBEEF) begin
      failures++;
      $display("FAIL write_through_readback got=%h exp=beef", obs[9].cwd);
    end
  endtask

  task automatic test_simultaneous();
    int acks;
    clear_sched();
    s_miss[0] = 1'b1; s_maddr[0] = 16'($urandom);
    for (int t = 0; t < 14; t++) begin
      s_wr[t] = 1'b1; s_waddr[t] = 16'h5550; s_wdata[t] = 16'h1357;
    end
    build_expect(16);
    capture(16);
    acks = 0;
    for (int t = 0; t < 16; t++) begin
      checks++;
      if (obs[t] !== exp_c[t]) begin
        failures++;
        $display("FAIL simultaneous cycle %0d got=%h exp=%h", t, obs[t], exp_c[t]);
      end
      if (t <= 12 && obs[t].ack === 1'b1) acks++;
    end
    checks++;
    if (acks != 0 || obs[13].ack !== 1'b1) begin
      failures++;
      $display("FAIL simultaneous_ack got=early%0d/c13=%b exp=early0/c13=1", acks, obs[13].ack);
    end
  endtask

  task automatic test_reset_mid_fill();
    int tags, late_writes;
    clear_sched();
    s_miss[0] = 1'b1; s_maddr[0] = 16'($urandom);
    s_rst[6] = 1'b1;
    build_expect(16);
    capture(16);
    tags = 0; late_writes = 0;
    for (int t = 0; t < 16; t++) begin
      checks++;
      if (obs[t] !== exp_c[t]) begin
        failures++;
        $display("FAIL reset_mid_fill cycle %0d got=%h exp=%h", t, obs[t], exp_c[t]);
      end
      if (obs[t].tag === 1'b1) tags++;
      if (t >= 6 && obs[t].wda === 1'b1) late_writes++;
    end
    checks++;
    if (tags != 0 || late_writes != 0) begin
      failures++;
      $display("FAIL reset_mid_fill_stray got=tags%0d/writes%0d exp=tags0/writes0", tags, late_writes);
    end
  endtask

  task automatic test_back_to_back();
    int s, n;
    clear_sched();
    s_miss[0]  = 1'b1; s_maddr[0]  = 16'hFFFE;
    s_miss[13] = 1'b1; s_maddr[13] = 16'h0008;
    s = 13;
    for (int f = 0; f < 4; f++) begin
      s = s + 13 + $urandom_range(0, 3);
      s_miss[s] = 1'b1; s_maddr[s] = 16'($urandom);
    end
    n = s + 18;
    for (int t = 1; t < n; t++) begin
      if ($urandom_range(0, 1) == 1) begin
        s_wr[t] = 1'b1; s_waddr[t] = 16'($urandom); s_wdata[t] = 16'($urandom);
      end
    end
    build_expect(n);
    capture(n);
    for (int t = 0; t < n; t++) begin
      checks++;
      if (obs[t] !== exp_c[t]) begin
        failures++;
        $display("FAIL back_to_back cycle %0d got=%h exp=%h", t, obs[t], exp_c[t]);
      end
    end
    checks++;
    if (obs[1].addr !== 16'hFFF0 || obs[8].addr !== 16'hFFFE) begin
      failures++;
      $display("FAIL wrap_addr got=%h..%h exp=fff0..fffe", obs[1].addr, obs[8].addr);
    end
    checks++;
    if (obs[13].busy !== 1'b1 || obs[14].en !== 1'b1 || obs[14].addr !== 16'h0000) begin
      failures++;
      $display("FAIL back_to_back_start got=busy%b en%b addr=%h exp=busy1 en1 addr=0000",
               obs[13].busy, obs[14].en, obs[14].addr);
    end
  endtask

  task automatic test_random();
    int n, cool;
    logic [31:0] w;
    n = 300;
    cool = 0;
    clear_sched();
    for (int t = 0; t < n; t++) begin
      if (t < n - 20 && cool == 0 && $urandom_range(0, 99) < 2) begin
        s_rst[t] = 1'b1;
        cool = 6;
      end else if (cool > 0) cool--;
      else if (t < n - 20 && $urandom_range(0, 5) == 0) begin
        s_miss[t] = 1'b1; s_maddr[t] = 16'($urandom);
      end
      if ($urandom_range(0, 2) == 0) begin
        s_wr[t] = 1'b1; s_waddr[t] = 16'($urandom); s_wdata[t] = 16'($urandom);
      end
    end
    build_expect(n);
    capture(n);
    for (int t = 0; t < n; t++) begin
      checks++;
      if (obs[t] !== exp_c[t]) begin
        failures++;
        $display("FAIL random cycle %0d got=%h exp=%h", t, obs[t], exp_c[t]);
      end
      if (obs[t].wda === 1'b1) begin
        checks++;
        if (exp_q.size() == 0) begin
          failures++;
          $display("FAIL random_sb cycle %0d got=%h@%h exp=no write", t, obs[t].cwd, obs[t].cwa);
        end else begin
          w = exp_q.pop_front();
          if ({obs[t].cwa, obs[t].cwd} !== w) begin
            failures++;
            $display("FAIL random_sb cycle %0d got=%h exp=%h", t, {obs[t].cwa, obs[t].cwd}, w);
          end
        end
      end
    end
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL random_sb_leftover got=%0d exp=0", exp_q.size());
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    for (int i = 0; i < 4; i++) pipe_d[i] = '0;
    for (int i = 0; i < 32768; i++) ref_mem[i] = 16'($urandom);
    @(posedge clk); #1;
    sync_mem();
    test_reset();
    test_basic_fill();
    test_write_through();
    test_simultaneous();
    test_reset_mid_fill();
    test_back_to_back();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
